// File: rtl/memory_arb_pkg.sv
// Shared types for the three-port memory arbiter: FSM states, requester
// indices and the one-hot requester vector type.
package memory_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    localparam int NUM_REQ = 3;
    localparam int REQ_IF  = 0;
    localparam int REQ_D   = 1;
    localparam int REQ_X   = 2;

    typedef logic [NUM_REQ-1:0] req_onehot_t;

endpackage

// File: rtl/memory_arb_picker.sv
// Combinational winner selection: starved requesters first, then fixed
// order X > D > IF inside the chosen pool.
module memory_arb_picker
    import memory_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] starved_i,
    output logic [NUM_REQ-1:0] win_o
);

    logic [NUM_REQ-1:0] pool;

    always_comb begin
        pool = req_i & starved_i;
        if (pool == '0) begin
            pool = req_i;
        end
        win_o = '0;
        if (pool[REQ_X]) begin
            win_o[REQ_X] = 1'b1;
        end else if (pool[REQ_D]) begin
            win_o[REQ_D] = 1'b1;
        end else if (pool[REQ_IF]) begin
            win_o[REQ_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Three-port (IF / D / X) arbiter in front of a fixed-latency memory, with
// aging-based starvation guard and CPU stall. Optional misaligned-access
// trap enabled by MEMORY_ARB_ALIGN_CHECK_EN.
module memory_port_arbiter
    import memory_arb_pkg::*;
#(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16,
    parameter int LATENCY   = 1,
    parameter int MAX_WAIT  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [ADDR_BITS-1:0] if_addr,
    output logic                 if_gnt,
    output logic                 if_rvalid,
    output logic [DATA_BITS-1:0] if_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_BITS-1:0] d_addr,
    input  logic [DATA_BITS-1:0] d_wdata,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [DATA_BITS-1:0] d_rdata,
    input  logic                 x_req,
    input  logic                 x_we,
    input  logic [ADDR_BITS-1:0] x_addr,
    input  logic [DATA_BITS-1:0] x_wdata,
    output logic                 x_gnt,
    output logic                 x_rvalid,
    output logic [DATA_BITS-1:0] x_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_BITS-2:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic [DATA_BITS-1:0] mem_rdata,
    output logic                 stall,
    output logic                 err
);

    localparam int AW = $clog2(MAX_WAIT + 1);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [AW-1:0] AGE_MAX  = AW'(MAX_WAIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

    arb_state_e           state_q, state_d;
    req_onehot_t          owner_q, owner_d;
    logic                 we_q, we_d;
    logic [ADDR_BITS-2:0] waddr_q, waddr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        age_q [NUM_REQ];
    logic [AW-1:0]        age_d [NUM_REQ];
    logic [DATA_BITS-1:0] rdata_q [NUM_REQ];
    logic [DATA_BITS-1:0] rdata_d [NUM_REQ];

    req_onehot_t          req_vec, starved_vec, win, gnt_vec;
    logic                 arb_en, sel_we;
    logic [ADDR_BITS-2:0] sel_waddr;
    logic [DATA_BITS-1:0] sel_wdata;

`ifdef MEMORY_ARB_ALIGN_CHECK_EN
    logic sel_odd, mis_q, mis_d;
`else
    logic addr_lsb_unused;
    assign addr_lsb_unused = ^{if_addr[0], d_addr[0], x_addr[0]};
`endif

    assign req_vec = {x_req, d_req, if_req};
    assign arb_en  = !rst && (state_q == IDLE || state_q == DONE);
    assign gnt_vec = arb_en ? win : '0;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            starved_vec[i] = (age_q[i] == AGE_MAX);
        end
    end

    memory_arb_picker u_picker (
        .req_i     (req_vec),
        .starved_i (starved_vec),
        .win_o     (win)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_waddr = if_addr[ADDR_BITS-1:1];
        sel_wdata = '0;
`ifdef MEMORY_ARB_ALIGN_CHECK_EN
        sel_odd   = if_addr[0];
`endif
        if (win[REQ_X]) begin
            sel_we    = x_we;
            sel_waddr = x_addr[ADDR_BITS-1:1];
            sel_wdata = x_wdata;
`ifdef MEMORY_ARB_ALIGN_CHECK_EN
            sel_odd   = x_addr[0];
`endif
        end else if (win[REQ_D]) begin
            sel_we    = d_we;
            sel_waddr = d_addr[ADDR_BITS-1:1];
            sel_wdata = d_wdata;
`ifdef MEMORY_ARB_ALIGN_CHECK_EN
            sel_odd   = d_addr[0];
`endif
        end
    end

    // Age counts every waiting cycle, including while another port owns memory.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            age_d[i] = age_q[i];
            if (!req_vec[i] || gnt_vec[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] != AGE_MAX) begin
                age_d[i] = age_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            rdata_d[i] = rdata_q[i];
        end
`ifdef MEMORY_ARB_ALIGN_CHECK_EN
        mis_d = mis_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (win != '0) begin
                    owner_d = win;
                    we_d    = sel_we;
                    waddr_d = sel_waddr;
                    wdata_d = sel_wdata;
                    cnt_d   = '0;
                    state_d = ACCESS;
`ifdef MEMORY_ARB_ALIGN_CHECK_EN
                    mis_d = sel_odd;
                    if (sel_odd) begin
                        state_d = DONE;
                    end
`endif
                end else begin
                    owner_d = '0;
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (owner_q[i] && !we_q) begin
                            rdata_d[i] = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                age_q[i]   <= '0;
                rdata_q[i] <= '0;
            end
`ifdef MEMORY_ARB_ALIGN_CHECK_EN
            mis_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                age_q[i]   <= age_d[i];
                rdata_q[i] <= rdata_d[i];
            end
`ifdef MEMORY_ARB_ALIGN_CHECK_EN
            mis_q <= mis_d;
`endif
        end
    end

    assign if_gnt    = gnt_vec[REQ_IF];
    assign d_gnt     = gnt_vec[REQ_D];
    assign x_gnt     = gnt_vec[REQ_X];
    assign if_rvalid = !rst && state_q == DONE && owner_q[REQ_IF];
    assign d_rvalid  = !rst && state_q == DONE && owner_q[REQ_D];
    assign x_rvalid  = !rst && state_q == DONE && owner_q[REQ_X];
    assign if_rdata  = rdata_q[REQ_IF];
    assign d_rdata   = rdata_q[REQ_D];
    assign x_rdata   = rdata_q[REQ_X];

    // Write strobe only on the first ACCESS cycle; address/data held throughout.
    assign mem_en    = !rst && state_q == ACCESS;
    assign mem_we    = mem_en && we_q && (cnt_q == '0);
    assign mem_addr  = waddr_q;
    assign mem_wdata = wdata_q;

    assign stall = !rst && (if_req || d_req ||
                   (state_q == ACCESS && (owner_q[REQ_IF] || owner_q[REQ_D])));

`ifdef MEMORY_ARB_ALIGN_CHECK_EN
    assign err = !rst && state_q == DONE && mis_q;
`else
    assign err = 1'b0;
`endif

endmodule
